id_ex_stage: RTL

//  Decode-to-execute pipeline register for the RV64 core; directly feeds the ALU rs1/rs2/control inputs.

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubbling.
// Optional ID_EX_PERF_EN adds stall_cnt/bubble_cnt performance counter ports.
module id_ex_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [RA_W-1:0]   in_rs1_addr,
  input  logic [RA_W-1:0]   in_rs2_addr,
  input  logic [RA_W-1:0]   in_rd_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic              in_uses_rs2,
  input  logic [CTRL_W-1:0] in_alu_ctrl,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              exmem_wen,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [XLEN-1:0]   exmem_data,
  input  logic              memwb_wen,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_rs1,
  output logic [XLEN-1:0]   alu_rs2,
  output logic [CTRL_W-1:0] alu_control,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_pc,
  output logic [RA_W-1:0]   out_rd,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write
);

  logic [RA_W-1:0] rs1_addr_q;
  logic [RA_W-1:0] rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            use_imm_q;

  logic            adv;
  logic            hazard;
  logic            take;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // EX/MEM wins over MEM/WB; x0 is hardwired to zero regardless of held data.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic [XLEN-1:0] held,
    input logic            ex_wen,
    input logic [RA_W-1:0] ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_wen,
    input logic [RA_W-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (src == '0)                   return '0;
    else if (ex_wen && ex_rd == src) return ex_data;
    else if (wb_wen && wb_rd == src) return wb_data;
    else                             return held;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_sel(rs1_addr_q, rs1_data_q, exmem_wen, exmem_rd, exmem_data,
                      memwb_wen, memwb_rd, memwb_data);
    fwd_rs2 = fwd_sel(rs2_addr_q, rs2_data_q, exmem_wen, exmem_rd, exmem_data,
                      memwb_wen, memwb_rd, memwb_data);
  end

  always_comb begin
    adv    = ~out_valid | out_ready;
    hazard = out_valid & out_mem_read & (out_rd != '0) &
             ((in_rs1_addr == out_rd) | (in_uses_rs2 & (in_rs2_addr == out_rd)));
    in_ready = ~reset & adv & ~hazard & ~flush;
    take     = in_valid & in_ready;
  end

  assign alu_rs1        = fwd_rs1;
  assign alu_rs2        = use_imm_q ? imm_q : fwd_rs2;
  assign out_store_data = fwd_rs2;

  // Held instruction; during a stall the operands absorb forwarded values so retiring results are not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      alu_control   <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      use_imm_q     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= take;
      if (take) begin
        out_pc        <= in_pc;
        out_rd        <= in_rd_addr;
        out_reg_write <= in_reg_write;
        out_mem_read  <= in_mem_read;
        out_mem_write <= in_mem_write;
        alu_control   <= in_alu_ctrl;
        rs1_addr_q    <= in_rs1_addr;
        rs2_addr_q    <= in_rs2_addr;
        rs1_data_q    <= in_rs1_data;
        rs2_data_q    <= in_rs2_data;
        imm_q         <= in_imm;
        use_imm_q     <= in_use_imm;
      end
    end else begin
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end
  end

`ifdef ID_EX_PERF_EN
  // Free-running wrap-around counters for stalled offers and load-use bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid & ~in_ready)
        stall_cnt <= stall_cnt + 32'd1;
      if (adv & hazard & in_valid & ~flush)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
